// File: rtl/uart_core.sv
// Full-duplex 8N1 UART: LSB-first transmitter and 16x-oversampled receiver
// with a sticky receive-ready flag.
module uart_core #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] din,
    input  logic       wr_en,
    output logic       tx,
    output logic       tx_busy,
    input  logic       rx,
    output logic       rdy,
    input  logic       rdy_clr,
    output logic [7:0] dout
);

    localparam int TX_DIV = CLK_HZ / BAUD;
    localparam int RX_DIV = CLK_HZ / (16 * BAUD);
    localparam int TXW    = $clog2(TX_DIV + 1);
    localparam int RXW    = $clog2(RX_DIV + 1);

    typedef enum logic [1:0] {
        TX_IDLE, TX_START, TX_DATA, TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP
    } rx_state_t;

    tx_state_t      tx_state;
    logic [TXW-1:0] tx_cnt;
    logic [2:0]     tx_bit;
    logic [7:0]     tx_shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
        end else if (tx_state == TX_IDLE) begin
            if (wr_en && !tx_busy) begin
                tx_shift <= din;
                tx_cnt   <= '0;
                tx       <= 1'b0;
                tx_busy  <= 1'b1;
                tx_state <= TX_START;
            end
        end else if (tx_cnt != TXW'(TX_DIV - 1)) begin
            tx_cnt <= tx_cnt + 1'b1;
        end else begin
            tx_cnt <= '0;
            unique case (tx_state)
                TX_START: begin
                    tx       <= tx_shift[0];
                    tx_shift <= {1'b0, tx_shift[7:1]};
                    tx_bit   <= '0;
                    tx_state <= TX_DATA;
                end
                TX_DATA: begin
                    if (tx_bit == 3'd7) begin
                        tx       <= 1'b1;
                        tx_state <= TX_STOP;
                    end else begin
                        tx       <= tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        tx_bit   <= tx_bit + 1'b1;
                    end
                end
                default: begin
                    tx_busy  <= 1'b0;
                    tx_state <= TX_IDLE;
                end
            endcase
        end
    end

    logic           rx_s1;
    logic           rx_s2;
    logic [RXW-1:0] rx_div;
    logic           rx_tick;
    rx_state_t      rx_state;
    logic [3:0]     rx_ticks;
    logic [2:0]     rx_bit;
    logic [7:0]     rx_shift;

    assign rx_tick = (rx_div == RXW'(RX_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1  <= 1'b1;
            rx_s2  <= 1'b1;
            rx_div <= '0;
        end else begin
            rx_s1  <= rx;
            rx_s2  <= rx_s1;
            rx_div <= rx_tick ? '0 : rx_div + 1'b1;
        end
    end

    // rdy_clr is applied first so a completing byte on the same edge wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            rx_ticks <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rdy      <= 1'b0;
            dout     <= '0;
        end else begin
            if (rdy_clr)
                rdy <= 1'b0;
            unique case (rx_state)
                RX_IDLE: begin
                    if (!rx_s2) begin
                        rx_ticks <= '0;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_tick) begin
                        if (rx_ticks == 4'd7) begin
                            rx_ticks <= '0;
                            rx_bit   <= '0;
                            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                        end else begin
                            rx_ticks <= rx_ticks + 1'b1;
                        end
                    end
                end
                RX_DATA: begin
                    if (rx_tick) begin
                        rx_ticks <= rx_ticks + 1'b1;
                        if (rx_ticks == 4'd15) begin
                            rx_shift <= {rx_s2, rx_shift[7:1]};
                            rx_bit   <= rx_bit + 1'b1;
                            if (rx_bit == 3'd7)
                                rx_state <= RX_STOP;
                        end
                    end
                end
                default: begin
                    if (rx_tick) begin
                        rx_ticks <= rx_ticks + 1'b1;
                        if (rx_ticks == 4'd15) begin
                            if (rx_s2) begin
                                dout <= rx_shift;
                                rdy  <= 1'b1;
                            end
                            rx_state <= RX_IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_core.sv
// Bench for uart_core: per-cycle frame model for tx, settled-state model
// for the receiver, plus directed literal expectations.
module tb_uart_core;

    localparam int CLK_HZ = 1_600_000;
    localparam int BAUD   = 10_000;
    localparam int TX_DIV = CLK_HZ / BAUD;
    localparam int RX_DIV = CLK_HZ / (16 * BAUD);
    localparam int BIT    = TX_DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din = 8'h00;
    logic       wr_en = 1'b0;
    logic       tx;
    logic       tx_busy;
    logic       rx;
    logic       rdy;
    logic       rdy_clr = 1'b0;
    logic [7:0] dout;

    logic rx_drv = 1'b1;
    logic loop = 1'b0;
    assign rx = loop ? tx : rx_drv;

    uart_core #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .wr_en(wr_en),
        .tx(tx), .tx_busy(tx_busy), .rx(rx), .rdy(rdy),
        .rdy_clr(rdy_clr), .dout(dout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // transmit model: a frame is 10 bit slots of TX_DIV cycles after accept
    logic       m_active = 1'b0;
    int         m_n = 0;
    logic [7:0] m_byte = 8'h00;
    // receive model: what rdy/dout must be once the line has settled
    logic       m_rdy = 1'b0;
    logic [7:0] m_dout = 8'h00;
    logic       rx_settled = 1'b1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 20)
                $display("FAIL %s: got %0h want %0h at %0t",
                         name, act, exp, $time);
        end
    endtask

    function automatic logic exp_tx();
        int idx;
        if (!m_active) return 1'b1;
        idx = m_n / TX_DIV;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return m_byte[idx-1];
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_n      <= 0;
        end else if (m_active) begin
            if (m_n == 10 * TX_DIV - 1) m_active <= 1'b0;
            m_n <= m_n + 1;
        end else if (wr_en) begin
            m_active <= 1'b1;
            m_n      <= 0;
            m_byte   <= din;
        end
    end

    always @(negedge clk) begin
        check("tx", 32'(tx), 32'(exp_tx()));
        check("tx_busy", 32'(tx_busy), 32'(m_active));
        if (rx_settled) begin
            check("rdy", 32'(rdy), 32'(m_rdy));
            check("dout", 32'(dout), 32'(m_dout));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        din = b;
        wr_en = 1'b1;
        cyc(1);
        wr_en = 1'b0;
    endtask

    task automatic watch_frame(input logic [9:0] bits, input bit inject);
        int busy = 0;
        for (int k = 0; k < 12 * TX_DIV; k++) begin
            if (k < 10 * TX_DIV && k % TX_DIV == TX_DIV / 2)
                check($sformatf("txbit%0d", k / TX_DIV), 32'(tx),
                      32'(bits[k / TX_DIV]));
            if (tx_busy) busy++;
            if (inject && k == 3 * TX_DIV) begin
                din = 8'hFF;
                wr_en = 1'b1;
            end
            if (inject && k == 3 * TX_DIV + 1) wr_en = 1'b0;
            cyc(1);
        end
        check("busy_len", 32'(busy), 32'(10 * TX_DIV));
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (tx_busy && k < 12 * BIT) begin
            cyc(1);
            k++;
        end
        check(name, 32'(k < 12 * BIT), 32'd1);
    endtask

    task automatic rx_frame(input logic [7:0] b, input bit good);
        rx_settled = 1'b0;
        rx_drv = 1'b0;
        cyc(BIT);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            cyc(BIT);
        end
        if (good) begin
            rx_drv = 1'b1;
            cyc(12 * RX_DIV);
            check("rdy_in_time", 32'(rdy), 32'd1);
            cyc(BIT - 12 * RX_DIV + 2);
            m_dout = b;
            m_rdy = 1'b1;
        end else begin
            rx_drv = 1'b0;
            cyc(12 * RX_DIV);
            rx_drv = 1'b1;
            cyc(2 * BIT);
        end
        rx_settled = 1'b1;
    endtask

    task automatic clear();
        rdy_clr = 1'b1;
        cyc(1);
        rdy_clr = 1'b0;
        m_rdy = 1'b0;
        check("rdy_after_clr", 32'(rdy), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: sim time %0t exceeded", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] lb [3];
        bit seen;
        lb[0] = 8'h00;
        lb[1] = 8'hA5;
        lb[2] = 8'hFF;

        // reset held while inputs toggle
        for (int i = 0; i < 20; i++) begin
            wr_en = i[0];
            rx_drv = ~i[0];
            din = 8'hA5;
            cyc(1);
        end
        wr_en = 1'b0;
        rx_drv = 1'b1;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_rdy", 32'(rdy), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        rst_n = 1'b1;
        cyc(3);

        // 0x41 frame with an ignored 0xFF request mid-frame
        send(8'h41);
        watch_frame(10'h282, 1'b1);

        // receive 0x35, then clear
        rx_frame(8'h35, 1'b1);
        check("rx35_dout", 32'(dout), 32'h35);
        check("rx35_rdy", 32'(rdy), 32'd1);
        clear();

        // overrun keeps rdy and takes the newest byte
        rx_frame(8'h11, 1'b1);
        rx_frame(8'h22, 1'b1);
        check("overrun_dout", 32'(dout), 32'h22);
        check("overrun_rdy", 32'(rdy), 32'd1);

        // rdy_clr held across completion: the new byte still sets rdy
        rdy_clr = 1'b1;
        seen = 1'b0;
        fork
            rx_frame(8'h5A, 1'b1);
            begin
                cyc(1);
                for (int k = 0; k < 11 * BIT && !seen; k++) begin
                    if (rdy) begin
                        seen = 1'b1;
                        rdy_clr = 1'b0;
                    end else begin
                        cyc(1);
                    end
                end
                rdy_clr = 1'b0;
            end
        join
        check("set_wins", 32'(seen), 32'd1);
        check("set_wins_dout", 32'(dout), 32'h5A);
        clear();
        clear();

        // short low glitch produces nothing
        rx_drv = 1'b0;
        cyc(3 * RX_DIV);
        rx_drv = 1'b1;
        cyc(2 * BIT);
        check("glitch_rdy", 32'(rdy), 32'd0);

        // framing error leaves rdy/dout alone
        rx_frame(8'h77, 1'b0);
        check("frame_err_rdy", 32'(rdy), 32'd0);
        check("frame_err_dout", 32'(dout), 32'h5A);

        // loopback
        loop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rx_settled = 1'b0;
            send(lb[i]);
            wait_idle("lb_timeout");
            cyc(4);
            m_dout = lb[i];
            m_rdy = 1'b1;
            rx_settled = 1'b1;
            check($sformatf("lb_dout%0d", i), 32'(dout), 32'(lb[i]));
            check($sformatf("lb_rdy%0d", i), 32'(rdy), 32'd1);
            clear();
        end
        loop = 1'b0;

        // back-to-back: accepted the cycle after tx_busy falls
        send(8'h3C);
        wait_idle("b2b_timeout");
        send(8'hC3);
        watch_frame(10'h386, 1'b0);

        // reset in the middle of a frame
        send(8'h96);
        cyc(4 * TX_DIV + 7);
        rst_n = 1'b0;
        m_rdy = 1'b0;
        m_dout = 8'h00;
        #1;
        check("midrst_tx", 32'(tx), 32'd1);
        check("midrst_busy", 32'(tx_busy), 32'd0);
        cyc(5);
        rst_n = 1'b1;
        cyc(2);
        check("midrst_rdy", 32'(rdy), 32'd0);
        check("midrst_dout", 32'(dout), 32'd0);
        send(8'h41);
        watch_frame(10'h282, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
